// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: ROM/function commands, slave FSM states,
// fixed DS18B20 scratchpad bytes and the Dallas CRC8 polynomial.
package onewire_pkg;

    localparam logic [7:0] CMD_SKIP_ROM     = 8'hCC;
    localparam logic [7:0] CMD_CONVERT_T    = 8'h44;
    localparam logic [7:0] CMD_READ_SCRATCH = 8'hBE;

    localparam logic [7:0] SP_TH    = 8'h4B;
    localparam logic [7:0] SP_TL    = 8'h46;
    localparam logic [7:0] SP_CFG   = 8'h7F;
    localparam logic [7:0] SP_RSVD0 = 8'hFF;
    localparam logic [7:0] SP_RSVD1 = 8'h0C;
    localparam logic [7:0] SP_RSVD2 = 8'h10;

    localparam logic [7:0]  CRC8_POLY = 8'h8C;
    localparam logic [15:0] TEMP_POR  = 16'h0550;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRES_WAIT,
        ST_PRES,
        ST_ROM_CMD,
        ST_FUNC_CMD,
        ST_CONV,
        ST_TX,
        ST_IGNORE
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Scratchpad byte by index; index 8 is the running CRC.
    function automatic logic [7:0] scratch_byte(input logic [3:0]  idx,
                                                input logic [15:0] temp,
                                                input logic [7:0]  crc);
        case (idx)
            4'd0:    return temp[7:0];
            4'd1:    return temp[15:8];
            4'd2:    return SP_TH;
            4'd3:    return SP_TL;
            4'd4:    return SP_CFG;
            4'd5:    return SP_RSVD0;
            4'd6:    return SP_RSVD1;
            4'd7:    return SP_RSVD2;
            4'd8:    return crc;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Serial Dallas/Maxim CRC8 (reflected polynomial 0x8C), one data bit per enabled cycle.
module onewire_crc8
    import onewire_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = (crc_q >> 1) ^ (((crc_q[0] ^ bit_in) == 1'b1) ? CRC8_POLY : 8'h00);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/ds18b20_slave.sv
// DS18B20 1-Wire responder: reset/presence, Skip ROM, Convert T and Read Scratchpad
// with CRC8, driving an open-drain DQ line (dq_out=1 means release).
module ds18b20_slave
    import onewire_pkg::*;
#(
    parameter int CLK_PER_US   = 1,
    parameter int RESET_MIN_US = 480,
    parameter int PRES_WAIT_US = 30,
    parameter int PRES_US      = 120,
    parameter int SAMPLE_US    = 30,
    parameter int HOLD_US      = 45,
    parameter int CONV_US      = 750000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dq_in,
    output logic        dq_out,
    input  logic [15:0] temp_in,
    output logic [15:0] temp_reg,
    output logic        conv_busy,
    output logic [7:0]  cmd,
    output logic        cmd_stb
);

    localparam int RESET_CYC  = RESET_MIN_US * CLK_PER_US;
    localparam int PWAIT_CYC  = PRES_WAIT_US * CLK_PER_US;
    localparam int PRES_CYC   = PRES_US * CLK_PER_US;
    localparam int SAMPLE_CYC = SAMPLE_US * CLK_PER_US;
    localparam int HOLD_CYC   = HOLD_US * CLK_PER_US;
    localparam int CONV_CYC   = CONV_US * CLK_PER_US;
    localparam int CNT_MAX    = max2(max2(PWAIT_CYC, PRES_CYC), max2(SAMPLE_CYC, HOLD_CYC));
    localparam int LOW_W      = $clog2(RESET_CYC + 1);
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int CONV_W     = $clog2(CONV_CYC + 1);
    localparam logic [6:0] TX_BITS = 7'd72;

    state_e            state_q, state_d;
    logic              dq_s1_q, dq_s2_q, dq_prev_q;
    logic [LOW_W-1:0]  low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              slot_act_q, slot_act_d, slot_drv_q, slot_drv_d;
    logic [6:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shreg_q, shreg_d, cmd_q, cmd_d;
    logic              cmd_stb_q, cmd_stb_d;
    logic              conv_busy_q, conv_busy_d;
    logic [CONV_W-1:0] conv_cnt_q, conv_cnt_d;
    logic [15:0]       temp_q, temp_d;
    logic              dq_out_q, dq_out_d;
    logic              fall, rise, bus_rst, tx_bit, crc_clr, crc_en, crc_bit;
    logic [7:0]        rx_byte, crc_val, sp_byte;

    // Our own pull-down must not look like master activity.
    assign fall    = dq_out_q && dq_prev_q && !dq_s2_q;
    assign rise    = dq_out_q && !dq_prev_q && dq_s2_q;
    assign bus_rst = rise && (low_cnt_q >= LOW_W'(RESET_CYC));
    assign sp_byte = scratch_byte(bit_cnt_q[6:3], temp_q, crc_val);

    onewire_crc8 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc_val)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch can be inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        slot_act_d  = slot_act_q;
        slot_drv_d  = slot_drv_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        cmd_d       = cmd_q;
        cmd_stb_d   = 1'b0;
        conv_busy_d = conv_busy_q;
        conv_cnt_d  = conv_cnt_q;
        temp_d      = temp_q;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        crc_bit     = 1'b0;
        tx_bit      = 1'b1;
        rx_byte     = {dq_s2_q, shreg_q[7:1]};

        if (!dq_out_q || dq_s2_q)                    low_cnt_d = '0;
        else if (low_cnt_q < LOW_W'(RESET_CYC))      low_cnt_d = low_cnt_q + 1'b1;
        else                                         low_cnt_d = low_cnt_q;

        if (conv_busy_q) begin
            if (conv_cnt_q >= CONV_W'(CONV_CYC - 1)) begin
                conv_busy_d = 1'b0;
                temp_d      = temp_in;
            end else begin
                conv_cnt_d = conv_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE, ST_IGNORE: ;
            ST_PRES_WAIT: begin
                if (cnt_q >= CNT_W'(PWAIT_CYC - 1)) begin
                    state_d = ST_PRES;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PRES: begin
                if (cnt_q >= CNT_W'(PRES_CYC - 1)) begin
                    state_d    = ST_ROM_CMD;
                    cnt_d      = '0;
                    bit_cnt_d  = '0;
                    slot_act_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ROM_CMD, ST_FUNC_CMD: begin
                if (fall) begin
                    slot_act_d = 1'b1;
                    slot_drv_d = 1'b0;
                    cnt_d      = '0;
                end else if (slot_act_q) begin
                    if (cnt_q >= CNT_W'(SAMPLE_CYC - 1)) begin
                        slot_act_d = 1'b0;
                        shreg_d    = rx_byte;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 7'd7) begin
                            bit_cnt_d = '0;
                            cmd_d     = rx_byte;
                            cmd_stb_d = 1'b1;
                            if (state_q == ST_ROM_CMD) begin
                                state_d = (rx_byte == CMD_SKIP_ROM) ? ST_FUNC_CMD : ST_IGNORE;
                            end else if (rx_byte == CMD_CONVERT_T) begin
                                state_d     = ST_CONV;
                                conv_busy_d = 1'b1;
                                conv_cnt_d  = '0;
                            end else if (rx_byte == CMD_READ_SCRATCH) begin
                                state_d = ST_TX;
                                crc_clr = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_CONV, ST_TX: begin
                tx_bit = (state_q == ST_CONV) ? !conv_busy_q : sp_byte[bit_cnt_q[2:0]];
                if (fall && bit_cnt_q != TX_BITS) begin
                    slot_act_d = 1'b1;
                    slot_drv_d = !tx_bit;
                    cnt_d      = '0;
                    if (state_q == ST_TX) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        crc_en    = (bit_cnt_q < 7'd64);
                        crc_bit   = tx_bit;
                    end
                end else if (slot_act_q) begin
                    if (cnt_q >= CNT_W'(HOLD_CYC - 1)) begin
                        slot_act_d = 1'b0;
                        slot_drv_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (state_q == ST_TX && bit_cnt_q == TX_BITS) begin
                    state_d = ST_IGNORE;
                end
            end
        endcase

        // A long low pulse aborts any transaction; the conversion timer is left alone.
        if (bus_rst) begin
            state_d    = ST_PRES_WAIT;
            cnt_d      = '0;
            bit_cnt_d  = '0;
            slot_act_d = 1'b0;
            slot_drv_d = 1'b0;
        end

        dq_out_d = !((state_d == ST_PRES) || (slot_act_d && slot_drv_d));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_s1_q     <= 1'b1;
            dq_s2_q     <= 1'b1;
            dq_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            low_cnt_q   <= '0;
            cnt_q       <= '0;
            slot_act_q  <= 1'b0;
            slot_drv_q  <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            cmd_q       <= '0;
            cmd_stb_q   <= 1'b0;
            conv_busy_q <= 1'b0;
            conv_cnt_q  <= '0;
            temp_q      <= TEMP_POR;
            dq_out_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            dq_s1_q     <= dq_in;
            dq_s2_q     <= dq_s1_q;
            dq_prev_q   <= dq_s2_q;
            state_q     <= state_d;
            low_cnt_q   <= low_cnt_d;
            cnt_q       <= cnt_d;
            slot_act_q  <= slot_act_d;
            slot_drv_q  <= slot_drv_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            cmd_q       <= cmd_d;
            cmd_stb_q   <= cmd_stb_d;
            conv_busy_q <= conv_busy_d;
            conv_cnt_q  <= conv_cnt_d;
            temp_q      <= temp_d;
            dq_out_q    <= dq_out_d;
        end
    end

    assign dq_out    = dq_out_q;
    assign temp_reg  = temp_q;
    assign conv_busy = conv_busy_q;
    assign cmd       = cmd_q;
    assign cmd_stb   = cmd_stb_q;

endmodule

// File: tb/tb_ds18b20_slave.sv
// Self-checking bench for ds18b20_slave: a 1-Wire master drives a wired-AND DQ line
// and compares presence timing, scratchpad bytes and conversion results with a model.
`timescale 1ns/1ps
module tb_ds18b20_slave;

    localparam int CLK_PER_US = 1;
    localparam int CONV_US    = 100;
    localparam int SAMPLE_US  = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        master_low = 1'b0;
    logic        dq_line;
    logic        dq_out;
    logic [15:0] temp_in = 16'h0000;
    logic [15:0] temp_reg;
    logic        conv_busy;
    logic [7:0]  cmd;
    logic        cmd_stb;

    int n_pass;
    int n_checks;
    int cyc;
    int stb_cnt;
    int last_slot_start;
    logic [15:0] model_temp;
    logic [7:0]  exp_sp [9];
    logic [7:0]  got_sp [9];

    assign dq_line = !master_low && dq_out;

    always #500 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        stb_cnt <= stb_cnt + (cmd_stb ? 1 : 0);
    end

    ds18b20_slave #(
        .CLK_PER_US (CLK_PER_US),
        .CONV_US    (CONV_US)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dq_in     (dq_line),
        .dq_out    (dq_out),
        .temp_in   (temp_in),
        .temp_reg  (temp_reg),
        .conv_busy (conv_busy),
        .cmd       (cmd),
        .cmd_stb   (cmd_stb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_us(input int n);
        repeat (n * CLK_PER_US) @(posedge clk);
        #1;
    endtask

    // Dallas CRC8 computed bytewise from the reflected polynomial.
    function automatic logic [7:0] crc8_model(input logic [7:0] b0, b1, b2, b3,
                                              b4, b5, b6, b7);
        logic [7:0] data [8];
        logic [7:0] c;
        data = '{b0, b1, b2, b3, b4, b5, b6, b7};
        c = 8'h00;
        for (int i = 0; i < 8; i++) begin
            c = c ^ data[i];
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build_exp(input logic [15:0] t);
        exp_sp[0] = t[7:0];
        exp_sp[1] = t[15:8];
        exp_sp[2] = 8'h4B;
        exp_sp[3] = 8'h46;
        exp_sp[4] = 8'h7F;
        exp_sp[5] = 8'hFF;
        exp_sp[6] = 8'h0C;
        exp_sp[7] = 8'h10;
        exp_sp[8] = crc8_model(exp_sp[0], exp_sp[1], exp_sp[2], exp_sp[3],
                               exp_sp[4], exp_sp[5], exp_sp[6], exp_sp[7]);
    endtask

    task automatic bus_reset(input int low_us, output int t_lo, output int t_hi);
        t_lo = -1;
        t_hi = -1;
        master_low = 1'b1;
        wait_us(low_us);
        master_low = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            wait_us(1);
            if (dq_out === 1'b0 && t_lo < 0) t_lo = i;
            if (dq_out === 1'b1 && t_lo >= 0 && t_hi < 0) t_hi = i;
        end
    endtask

    task automatic reset_presence(input string tag);
        int lo, hi;
        bus_reset(600, lo, hi);
        check({tag, "_presence"}, (lo >= 0 && hi > lo), 1'b1);
    endtask

    task automatic write_bit(input logic b);
        last_slot_start = cyc;
        master_low = 1'b1;
        if (b) begin
            wait_us(5);
            master_low = 1'b0;
            wait_us(65);
        end else begin
            wait_us(60);
            master_low = 1'b0;
            wait_us(10);
        end
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
    endtask

    task automatic read_bit(output logic b);
        master_low = 1'b1;
        wait_us(5);
        master_low = 1'b0;
        wait_us(8);
        b = dq_line;
        wait_us(57);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    task automatic read_and_compare(input string tag);
        logic [7:0] v;
        reset_presence(tag);
        write_byte(8'hCC);
        write_byte(8'hBE);
        for (int k = 0; k < 9; k++) begin
            read_byte(v);
            got_sp[k] = v;
        end
        build_exp(model_temp);
        for (int k = 0; k < 9; k++) check($sformatf("%s_byte%0d", tag, k), got_sp[k], exp_sp[k]);
    endtask

    // A slot reads 0 until SAMPLE_US + CONV_US after the start of the 0x44 byte's last slot.
    task automatic do_convert(input string tag, input logic [15:0] t);
        int s;
        logic b;
        temp_in = t;
        reset_presence(tag);
        write_byte(8'hCC);
        write_byte(8'h44);
        check({tag, "_busy"}, conv_busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            s = cyc;
            read_bit(b);
            check($sformatf("%s_poll%0d", tag, i), b, ((s - last_slot_start) >= SAMPLE_US + CONV_US));
        end
        model_temp = t;
        check({tag, "_done"}, conv_busy, 1'b0);
        check({tag, "_temp_reg"}, temp_reg, model_temp);
    endtask

    initial begin
        int lo, hi, s0, lows;
        logic [7:0] v;
        model_temp = 16'h0550;

        wait_us(3);
        check("rst_dq_out", dq_out, 1'b1);
        check("rst_temp_reg", temp_reg, 16'h0550);
        check("rst_conv_busy", conv_busy, 1'b0);
        check("rst_cmd", cmd, 8'h00);
        check("rst_cmd_stb", cmd_stb, 1'b0);
        rst = 1'b0;
        wait_us(5);

        // T1: presence timing and a too-short low pulse
        bus_reset(500, lo, hi);
        check("t1_pres_start", (lo >= 30 && lo <= 36), 1'b1);
        check("t1_pres_len", hi - lo, 120);
        bus_reset(400, lo, hi);
        check("t1_short_no_pres", lo, -1);

        // T2: scratchpad after reset, known +85 degC CRC
        s0 = stb_cnt;
        reset_presence("t2");
        write_byte(8'hCC);
        check("t2_cmd_skip", cmd, 8'hCC);
        write_byte(8'hBE);
        check("t2_cmd_read", cmd, 8'hBE);
        check("t2_stb_count", stb_cnt - s0, 2);
        for (int k = 0; k < 9; k++) begin
            read_byte(v);
            got_sp[k] = v;
        end
        build_exp(model_temp);
        for (int k = 0; k < 9; k++) check($sformatf("t2_byte%0d", k), got_sp[k], exp_sp[k]);
        check("t2_crc_known", got_sp[8], 8'h1C);
        read_byte(v);
        check("t2_after_tx", v, 8'hFF);

        // T3/T4: conversions then readback
        do_convert("t3", 16'h0191);
        read_and_compare("t3_read");
        do_convert("t4", 16'hFF5E);
        read_and_compare("t4_read");
        do_convert("rand", 16'($urandom));
        read_and_compare("rand_read");

        // T5: unsupported ROM command
        reset_presence("t5");
        write_byte(8'h33);
        check("t5_cmd", cmd, 8'h33);
        read_byte(v);
        check("t5_ignored", v, 8'hFF);
        reset_presence("t5_recover");

        // T6: abort in the middle of byte 3
        reset_presence("t6");
        write_byte(8'hCC);
        write_byte(8'hBE);
        for (int k = 0; k < 3; k++) read_byte(v);
        for (int i = 0; i < 4; i++) read_bit(v[i]);
        read_and_compare("t6_reread");

        // Asynchronous rst during presence
        master_low = 1'b1;
        wait_us(600);
        master_low = 1'b0;
        wait_us(60);
        check("rst_mid_pres_low", dq_out, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_pres_release", dq_out, 1'b1);
        check("rst_mid_temp", temp_reg, 16'h0550);
        wait_us(3);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            wait_us(1);
            if (dq_out !== 1'b1) lows++;
        end
        check("rst_no_resume", lows, 0);
        model_temp = 16'h0550;
        read_and_compare("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
